// File: rtl/acc_window_monitor.sv
`default_nettype none
// ============================================================================
// Module      : acc_window_monitor
// Description : Samples a 16-bit saturating accumulator once per WINDOW
//               enabled cycles, computes the per-window increment and a
//               saturation flag, and queues each {sat, delta} result in a
//               DEPTH-entry FIFO drained over a valid/ready handshake.
//               Optional threshold alarm enabled by macro ACC_MON_THRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_window_monitor #(
    parameter int WINDOW = 256,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [15:0]            sum,
`ifdef ACC_MON_THRESH_EN
    input  logic [15:0]            thresh,
    output logic                   alarm,
`endif
    output logic [15:0]            out_delta,
    output logic                   out_sat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [LVL_W-1:0] c_lvl_one  = LVL_W'(1);
    localparam logic [LVL_W-1:0] c_depth    = LVL_W'(DEPTH);

    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_prev;
    logic [16:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [16:0]      r_head;
    logic             r_overflow;

    logic             w_boundary;
    logic [15:0]      w_delta;
    logic             w_sat;
    logic             w_pop;
    logic             w_push;
    logic             w_head_from_mem;
    logic             w_head_from_new;
    logic             w_buf_write;

    // The head register holds the oldest entry; the circular buffer holds the
    // entries queued behind it, so level counts head plus buffer.
    assign out_valid  = (r_level != '0);
    assign w_boundary = en && (r_cnt == c_cnt_last);
    // A drop in sum means the accumulator was cleared: count from zero.
    assign w_delta    = (sum >= r_prev) ? (sum - r_prev) : sum;
    assign w_sat      = (sum == 16'hFFFF);
    assign w_pop      = out_valid && out_ready;
    assign w_push     = w_boundary && ((r_level != c_depth) || w_pop);

    // Refill the head from the buffer when it has entries behind the head;
    // otherwise a new result goes straight to the head if it will be empty.
    assign w_head_from_mem = w_pop && (r_level > c_lvl_one);
    assign w_head_from_new = w_push && (!out_valid || (w_pop && (r_level == c_lvl_one)));
    assign w_buf_write     = w_push && !w_head_from_new;

    // Result storage behind the head; contents are don't-care when unused.
    always_ff @(posedge clk) begin
        if (rst && w_buf_write) begin
            r_mem[r_wr_ptr] <= {w_sat, w_delta};
        end
    end

    // Window counter, previous sample, FIFO bookkeeping and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_prev     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (en) begin
                r_cnt <= w_boundary ? '0 : (r_cnt + c_cnt_one);
            end
            if (w_boundary) begin
                r_prev <= sum;
            end
            if (w_boundary && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_buf_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_head_from_mem) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_head   <= r_mem[r_rd_ptr];
            end else if (w_head_from_new) begin
                r_head <= {w_sat, w_delta};
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef ACC_MON_THRESH_EN
    logic r_alarm;

    // Alarm tracks the latest window's delta, even when its push was dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alarm <= 1'b0;
        end else if (w_boundary) begin
            r_alarm <= (w_delta > thresh);
        end
    end

    assign alarm = r_alarm;
`else
    // No threshold comparator in this build.
`endif

    assign out_delta = r_head[15:0];
    assign out_sat   = r_head[16];
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_acc_window_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_window_monitor
// Description : Scoreboard bench for acc_window_monitor. A reference model
//               derives expected results from the window rules and queues
//               them; a monitor pops and compares on each DUT handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_window_monitor;

    localparam int WINDOW = 8;
    localparam int DEPTH  = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        en        = 1'b0;
    logic [15:0] sum       = '0;
    logic        out_ready = 1'b0;
    logic [15:0] out_delta;
    logic        out_sat;
    logic        out_valid;
    logic [2:0]  level;
    logic        overflow;
`ifdef ACC_MON_THRESH_EN
    logic [15:0] thresh = '0;
    logic        alarm;
`endif

    acc_window_monitor #(
        .WINDOW (WINDOW),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sum       (sum),
`ifdef ACC_MON_THRESH_EN
        .thresh    (thresh),
        .alarm     (alarm),
`endif
        .out_delta (out_delta),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;

    // Reference model state
    logic [16:0] exp_q[$];
    int          mdl_count   = 0;
    int          en_cycles   = 0;
    logic [15:0] mdl_prev    = '0;
    logic        mdl_ovf     = 1'b0;
    logic        mdl_alarm   = 1'b0;
    logic [16:0] last_head   = '0;
    bit          started     = 1'b0;
    bit          m_pop;
    bit          m_bnd;
    logic [15:0] m_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts enabled cycles since reset; every WINDOW-th one
    // is a sample point, whose result joins the expected queue if there is room.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            started   = 1'b1;
            en_cycles = 0;
            mdl_prev  = '0;
            mdl_count = 0;
            mdl_ovf   = 1'b0;
            mdl_alarm = 1'b0;
            last_head = '0;
            exp_q.delete();
        end else if (started) begin
            m_pop = (mdl_count > 0) && out_ready;
            m_bnd = en && ((en_cycles % WINDOW) == WINDOW - 1);
            if (en) en_cycles++;
            if (m_bnd) begin
                m_d = (sum >= mdl_prev) ? 16'(sum - mdl_prev) : sum;
`ifdef ACC_MON_THRESH_EN
                mdl_alarm = (m_d > thresh);
`endif
                if (mdl_count < DEPTH || m_pop) begin
                    exp_q.push_back({(sum == 16'hFFFF), m_d});
                    mdl_count++;
                end else begin
                    mdl_ovf = 1'b1;
                end
                mdl_prev = sum;
            end
            if (m_pop) mdl_count--;
        end
    end

    // Monitor: checks status every cycle, compares the presented head against
    // the queue front and pops it when the consumer accepts.
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("level", 32'(level), mdl_count);
            chk("out_valid", 32'(out_valid), 32'(mdl_count != 0));
            chk("overflow", 32'(overflow), 32'(mdl_ovf));
`ifdef ACC_MON_THRESH_EN
            chk("alarm", 32'(alarm), 32'(mdl_alarm));
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_empty: got valid entry %0h expected none at %0t",
                             {out_sat, out_delta}, $time);
                end else begin
                    chk("out_delta", 32'(out_delta), 32'(exp_q[0][15:0]));
                    chk("out_sat", 32'(out_sat), 32'(exp_q[0][16]));
                    last_head = exp_q[0];
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("held_delta", 32'(out_delta), 32'(last_head[15:0]));
                chk("held_sat", 32'(out_sat), 32'(last_head[16]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // One aligned window; v is presented on the sample cycle only.
    task automatic window(input logic [15:0] v, input bit rdy, input bit rdy_at_bnd);
        for (int i = 0; i < WINDOW; i++) begin
            en        = 1'b1;
            sum       = (i == WINDOW - 1) ? v : 16'($urandom);
            out_ready = (i == WINDOW - 1) ? rdy_at_bnd : rdy;
            tick();
        end
    endtask

    task automatic drain(input int n);
        en        = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // Basic deltas, saturation, restart
        window(16'd100, 1'b1, 1'b1);
        window(16'd350, 1'b1, 1'b1);
        window(16'd65000, 1'b1, 1'b1);
        window(16'hFFFF, 1'b1, 1'b1);
        window(16'd500, 1'b1, 1'b1);
        window(16'd20, 1'b1, 1'b1);

        // Backpressure past full, then drain
        for (int k = 1; k <= 5; k++) window(16'(10 * k), 1'b0, 1'b0);
        drain(8);

        // Full FIFO with a pop in the sample cycle
        do_reset();
        for (int k = 0; k < 4; k++) window(16'($urandom), 1'b0, 1'b0);
        window(16'($urandom), 1'b0, 1'b1);
        drain(8);

        // Reset mid-window with entries queued, then threshold alarm
        do_reset();
`ifdef ACC_MON_THRESH_EN
        thresh = 16'd200;
`endif
        window(16'd300, 1'b0, 1'b0);
        en = 1'b1;
        repeat (3) begin
            sum = 16'($urandom);
            tick();
        end
        do_reset();
        window(16'd250, 1'b1, 1'b1);
        window(16'd400, 1'b1, 1'b1);
        drain(3);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sum       = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
`ifdef ACC_MON_THRESH_EN
            if ($urandom_range(0, 31) == 0) thresh = 16'($urandom);
`endif
            tick();
        end
        rst = 1'b1;
        drain(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_window_monitor.md
# acc_window_monitor

Downstream consumer of the 16-bit saturating accumulator output. Samples the running `sum` once per fixed window of clock cycles and computes the per-window increment. It also flags saturation and queues each `{sat, delta}` result in a small FIFO. The FIFO drains over a valid/ready handshake to the reporting logic.

## Interface
- `WINDOW`, default 256: window length in clock cycles; legal range 2..65536.
- `DEPTH`, default 4: result FIFO depth; power of two, >= 2.
- `clk`  input  1: rising-edge clock, single clock domain.
- `rst`  input  1: reset, synchronous, active-low.
- `en`  input  1: window counter advances only while high.
- `sum`  input  16: accumulator output.
- `out_delta`  output  16: increment of `sum` over the window at FIFO head.
- `out_sat`  output  1: `sum` was 16'hFFFF at that window's sample point.
- `out_valid`  output  1: FIFO non-empty; head entry presented.
- `out_ready`  input  1: consumer accepts head entry.
- `level`  output  $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  output  1: sticky; set when a result was dropped.
- `thresh`  input  16: alarm threshold; present only with `ACC_MON_THRESH_EN`.
- `alarm`  output  1: window delta exceeded `thresh`; present only with `ACC_MON_THRESH_EN`.

## Operation
- **Window counter** `cnt` runs 0..WINDOW-1 while `en`=1 and wraps to 0. It holds while `en`=0.
- **Boundary cycle:** the cycle in which `en`=1 and `cnt`==WINDOW-1. In this cycle:
  - Sample `s = sum`.
  - If `s >= prev`, `delta = s - prev`. Otherwise `delta = s`: an accumulator clear is treated as a restart from 0.
  - `sat = (s == 16'hFFFF)`.
  - `prev <= s`.
  - Push `{sat, delta}` into the FIFO.
- **Arithmetic:** `delta` is computed in 16 bits and cannot go negative, because of the restart rule above.
- **First window after reset:** `prev`=0, so `delta = sum`.
- **FIFO:** circular buffer, DEPTH entries, with a head register driving `out_delta`/`out_sat`.
  - Pop occurs when `out_valid && out_ready`.
  - A push is accepted when `level < DEPTH`, or when a pop occurs in the same cycle.
  - Push and pop in the same cycle: `level` is unchanged and order is preserved.
  - Push while full and no pop: the entry is dropped, `overflow` is set to 1, and FIFO contents are unchanged.
- **`overflow`** clears only on reset.
- **Head registers** hold their value while `out_valid`=0 or `out_ready`=0. They never change while `out_valid`=1 and `out_ready`=0.
- **Reset values:** `cnt`=0, `prev`=0, FIFO empty, `level`=0, `out_valid`=0, `out_delta`=0, `out_sat`=0, `overflow`=0, `alarm`=0.

## Timing
- `rst` is sampled at the rising edge. While `rst`=0, all state is held at its reset values.
- On the first edge with `rst`=1 and `en`=1, `cnt` becomes 1. The first boundary is the WINDOW-th enabled cycle after reset release.
- **Latency:** the `sum` value present in the boundary cycle appears on the outputs one cycle later, provided the FIFO was empty. Otherwise it waits behind older entries.
- **`level` and `out_valid`** update on the edge that ends the push or pop cycle.
- **Back-to-back pops:** one entry per cycle while `out_ready`=1.
- **Reset mid-window:** the partial window is discarded and `prev` returns to 0. FIFO contents are lost and no entry is emitted for the partial window.
- **`en` deasserted during the boundary cycle:** no sample is taken. The sample happens on the next enabled cycle with `cnt`==WINDOW-1.

## Configuration
- Macro: `ACC_MON_THRESH_EN`.
- **Defined:**
  - The `thresh` input and `alarm` output exist.
  - At each boundary, `alarm <= (delta > thresh)`, registered and updated in the same edge as the push.
  - `alarm` holds between boundaries, even if the push was dropped.
  - `alarm` resets to 0.
- **Undefined:** neither port exists and no comparator logic is generated. All other behaviour is identical.

## Test plan
- **Basic deltas**, WINDOW=8, `en`=1, `out_ready`=1: `sum`=100 at the 1st boundary and 350 at the 2nd. Required: `out_delta`=100 then 250, `out_sat`=0, each one cycle after its boundary.
- **Saturation:** `prev`=65000, `sum`=16'hFFFF at the boundary. Required: `out_delta`=535, `out_sat`=1.
- **Restart:** `prev`=500, `sum`=20 at the boundary. Required: `out_delta`=20, `out_sat`=0.
- **Backpressure**, DEPTH=4, `out_ready`=0 for 5 boundaries with `sum`=10,20,30,40,50. Required:
  - `level`=4 and `overflow`=1 after the 5th boundary.
  - Raising `out_ready` drains deltas 10,10,10,10 on consecutive cycles, then `out_valid`=0.
- **Full with simultaneous pop:** FIFO full and `out_ready`=1 in the boundary cycle. Required: `level` stays 4, `overflow` stays 0, and the new entry appears last.
- **Reset mid-window and threshold:** `rst`=0 at `cnt`=3. Required:
  - All outputs are 0 on the next edge.
  - The next boundary comes WINDOW enabled cycles after release.
  - With `ACC_MON_THRESH_EN` and `thresh`=200, deltas 250 then 150 give `alarm`=1 then 0.
